// File: rtl/prog_clk_divider_if.sv
// Control and output bundle of the programmable clock divider.
// The master side drives enables, loads and ratios; the slave side drives clocks.
interface prog_clk_divider_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8
);
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*DIV_W-1:0] div_val;
    logic                    sync;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       pend;

    modport master (
        output en, load, div_val, sync,
        input  clk_out, tick, pend
    );

    modport slave (
        input  en, load, div_val, sync,
        output clk_out, tick, pend
    );
endinterface

// File: rtl/prog_clk_divider.sv
// Multi-channel run-time programmable integer clock divider.
// Ratio changes take effect only at period boundaries, sync, or stop.
module prog_clk_divider #(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    prog_clk_divider_if.slave io
);
    typedef logic [DIV_W-1:0] ratio_t;

    localparam ratio_t RST_N = ratio_t'(RESET_DIV);
    localparam ratio_t ONE   = ratio_t'(1);
    localparam ratio_t TWO   = ratio_t'(2);

    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    ratio_t            cnt_q [NUM_CH];
    ratio_t            cnt_d [NUM_CH];
    ratio_t            nact_q [NUM_CH];
    ratio_t            nact_d [NUM_CH];
    ratio_t            npend_q [NUM_CH];
    ratio_t            npend_d [NUM_CH];

    ratio_t            ld_val [NUM_CH];
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] clk_out_w;
    logic [NUM_CH-1:0] tick_w;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ratio_t     raw;
        logic [DIV_W:0] half;

        assign raw       = io.div_val[g*DIV_W +: DIV_W];
        assign ld_val[g] = (raw < TWO) ? TWO : raw;
        assign wrap[g]   = (cnt_q[g] == nact_q[g] - ONE);
        // High phase lasts ceil(N/2) cycles; extra bit avoids overflow at N=max
        assign half      = ({1'b0, nact_q[g]} + (DIV_W+1)'(1)) >> 1;
        assign clk_out_w[g] = run_q[g] & ({1'b0, cnt_q[g]} < half);
        assign tick_w[g]    = run_q[g] & (cnt_q[g] == '0);
    end

    assign io.clk_out = clk_out_w;
    assign io.tick    = tick_w;
    assign io.pend    = pend_q;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            run_d[i]   = run_q[i];
            pend_d[i]  = pend_q[i];
            cnt_d[i]   = cnt_q[i];
            nact_d[i]  = nact_q[i];
            npend_d[i] = npend_q[i];
            if (!io.en[i]) begin
                run_d[i]  = 1'b0;
                cnt_d[i]  = '0;
                pend_d[i] = 1'b0;
                if (io.load[i])
                    nact_d[i] = ld_val[i];
                else if (pend_q[i])
                    nact_d[i] = npend_q[i];
            end else if (!run_q[i]) begin
                run_d[i] = 1'b1;
                cnt_d[i] = '0;
                if (io.load[i])
                    nact_d[i] = ld_val[i];
            end else if (io.sync || wrap[i]) begin
                cnt_d[i]  = '0;
                pend_d[i] = 1'b0;
                if (io.load[i])
                    nact_d[i] = ld_val[i];
                else if (pend_q[i])
                    nact_d[i] = npend_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
                if (io.load[i]) begin
                    npend_d[i] = ld_val[i];
                    pend_d[i]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q  <= '0;
            pend_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]   <= '0;
                nact_q[i]  <= RST_N;
                npend_q[i] <= RST_N;
            end
        end else begin
            run_q  <= run_d;
            pend_q <= pend_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]   <= cnt_d[i];
                nact_q[i]  <= nact_d[i];
                npend_q[i] <= npend_d[i];
            end
        end
    end
endmodule

// File: tb/tb_prog_clk_divider.sv
// Randomised scoreboard bench for prog_clk_divider against a period-position model.
// Expected outputs are queued at stimulus time and checked by an independent monitor.
module tb_prog_clk_divider;
    localparam int NCH = 4;
    localparam int DW  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prog_clk_divider_if #(.NUM_CH(NCH), .DIV_W(DW)) bus ();

    prog_clk_divider #(.NUM_CH(NCH), .DIV_W(DW), .RESET_DIV(2)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    typedef struct packed {
        logic [NCH-1:0] c;
        logic [NCH-1:0] t;
        logic [NCH-1:0] p;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   ncyc  = 0;

    // Model: each channel is "running or not", a position within its
    // current period, the active ratio, and an optional pending ratio.
    int m_run [NCH];
    int m_pos [NCH];
    int m_n   [NCH];
    int m_np  [NCH];
    int m_pd  [NCH];

    task automatic step(input logic r, input logic [NCH-1:0] e,
                        input logic [NCH-1:0] l, input logic [31:0] d,
                        input logic s);
        exp_t x;
        @(negedge clk);
        rst         = r;
        bus.en      = e;
        bus.load    = l;
        bus.div_val = d;
        bus.sync    = s;
        for (int i = 0; i < NCH; i++) begin
            int v;
            v = int'(d[i*DW +: DW]);
            if (v < 2) v = 2;
            if (r) begin
                m_run[i] = 0; m_pos[i] = 0; m_n[i] = 2; m_pd[i] = 0;
            end else if (!e[i]) begin
                m_run[i] = 0; m_pos[i] = 0;
                if (m_pd[i] != 0) m_n[i] = m_np[i];
                m_pd[i] = 0;
                if (l[i]) m_n[i] = v;
            end else if (m_run[i] == 0) begin
                m_run[i] = 1; m_pos[i] = 0;
                if (l[i]) m_n[i] = v;
            end else begin
                int nxt;
                nxt = s ? 0 : (m_pos[i] + 1) % m_n[i];
                if (nxt == 0) begin
                    if (l[i]) m_n[i] = v;
                    else if (m_pd[i] != 0) m_n[i] = m_np[i];
                    m_pd[i] = 0;
                end else if (l[i]) begin
                    m_np[i] = v; m_pd[i] = 1;
                end
                m_pos[i] = nxt;
            end
            x.c[i] = (m_run[i] != 0) && (m_pos[i] < (m_n[i] + 1) / 2);
            x.t[i] = (m_run[i] != 0) && (m_pos[i] == 0);
            x.p[i] = (m_pd[i] != 0);
        end
        exp_q.push_back(x);
    endtask

    function automatic logic [31:0] pk(input int ch, input int v);
        logic [31:0] w;
        w = 32'(v & 8'hFF);
        return w << (DW * ch);
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (bus.clk_out !== e.c || bus.tick !== e.t || bus.pend !== e.p) begin
                    fails++;
                    $display("FAIL cyc%0d outputs: got clk_out=%b tick=%b pend=%b, want clk_out=%b tick=%b pend=%b",
                             ncyc, bus.clk_out, bus.tick, bus.pend, e.c, e.t, e.p);
                end
            end
            ncyc++;
        end
    end

    initial begin
        logic [NCH-1:0] en_r;
        logic [NCH-1:0] ld;
        logic [31:0]    dv;
        for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0; m_pos[i] = 0; m_n[i] = 2; m_np[i] = 2; m_pd[i] = 0;
        end
        rst = 1'b1; bus.en = '0; bus.load = '0; bus.div_val = '0; bus.sync = 1'b0;

        step(1, 4'b0000, 4'b0000, 0, 0);
        step(1, 4'b0000, 4'b0000, 0, 0);
        repeat (8) step(0, 4'b0001, 4'b0000, 0, 0);
        step(0, 4'b0001, 4'b0010, pk(1, 5), 0);
        repeat (12) step(0, 4'b0011, 4'b0000, 0, 0);
        step(0, 4'b0011, 4'b0100, pk(2, 4), 0);
        repeat (5) step(0, 4'b0111, 4'b0000, 0, 0);
        step(0, 4'b0111, 4'b0100, pk(2, 7), 0);
        repeat (16) step(0, 4'b0111, 4'b0000, 0, 0);
        step(0, 4'b0111, 4'b1000, pk(3, 0), 0);
        repeat (5) step(0, 4'b1111, 4'b0000, 0, 0);
        step(0, 4'b0111, 4'b1000, pk(3, 1), 0);
        repeat (5) step(0, 4'b1111, 4'b0000, 0, 0);
        step(0, 4'b0111, 4'b1000, pk(3, 255), 0);
        repeat (260) step(0, 4'b1111, 4'b0000, 0, 0);
        step(0, 4'b0000, 4'b0011, pk(0, 3) | pk(1, 6), 0);
        step(0, 4'b0001, 4'b0000, 0, 0);
        step(0, 4'b0011, 4'b0000, 0, 0);
        repeat (4) step(0, 4'b0011, 4'b0000, 0, 0);
        step(0, 4'b0011, 4'b0000, 0, 1);
        repeat (14) step(0, 4'b0011, 4'b0000, 0, 0);
        step(0, 4'b0011, 4'b0010, pk(1, 9), 0);
        step(0, 4'b0001, 4'b0000, 0, 0);
        repeat (3) step(0, 4'b0001, 4'b0000, 0, 0);
        repeat (20) step(0, 4'b0011, 4'b0000, 0, 0);
        step(1, 4'b0011, 4'b0000, 0, 0);
        repeat (6) step(0, 4'b0011, 4'b0000, 0, 0);

        en_r = 4'b1111;
        for (int k = 0; k < 3000; k++) begin
            ld = '0;
            dv = '0;
            for (int i = 0; i < NCH; i++) begin
                int v;
                if ($urandom_range(0, 39) == 0) en_r[i] = ~en_r[i];
                if ($urandom_range(0, 15) == 0) ld[i] = 1'b1;
                case ($urandom_range(0, 9))
                    0, 1:    v = int'($urandom_range(0, 3));
                    2:       v = ($urandom_range(0, 9) == 0) ? 255 : 254;
                    default: v = int'($urandom_range(2, 20));
                endcase
                dv = dv | pk(i, v);
            end
            step(($urandom_range(0, 599) == 0), en_r, ld, dv,
                 ($urandom_range(0, 29) == 0));
        end

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
